tc_to_7seg_multi: RTL and testbench
===================================

Name: tc_to_7seg_multi

Overview:
- Sequential, parametrised two's-complement to multi-digit 7-segment display driver.
- Takes a WIDTH-bit signed value on a load strobe and converts its magnitude to BCD with an iterative shift-add-3 (double-dabble) engine.
- Drives one active-low sign display and DIGITS active-low magnitude displays.
- Sits between datapath registers and the board HEX displays. Outputs are registered and hold the last result, so displays never show intermediate values.

Parameters:
- WIDTH, 8, input width in bits; legal range 2..16.
- DIGITS, 3, number of magnitude displays; must satisfy 10^DIGITS > 2^(WIDTH-1). Elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  start strobe; sampled only in IDLE.
- N  input  WIDTH  two's-complement operand; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  one-cycle pulse; Sign and Magnitude were updated on the preceding edge.
- Sign  output  7  active-low sign display.
- Magnitude  output  7*DIGITS  active-low digit displays; bits [6:0] are the least significant digit, [13:7] the next, and so on.

Behaviour:
- Reset is synchronous, active-high; the clock is clk.
- Reset values: state=IDLE, busy=0, valid=0, Sign=7'b1111111, every Magnitude digit=7'b1111111 (blank).
- Segment order within each digit is bit0=a(top) through bit6=g(middle). Active-low glyphs:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, blank=1111111
- FSM states: IDLE, SHIFT, ENCODE.
- IDLE:
  - If load=1, capture sign bit N[WIDTH-1] and the magnitude |N| as an unsigned WIDTH-bit value.
  - The most negative input -2^(WIDTH-1) gives magnitude 2^(WIDTH-1), with no overflow.
  - Clear the BCD accumulator, set the bit counter to WIDTH, go to SHIFT, and set busy=1.
- SHIFT:
  - Each cycle, add 3 to every BCD nibble that is >= 5, then shift {bcd, mag} left by one.
  - Decrement the counter. After WIDTH shift cycles, go to ENCODE.
- ENCODE (one cycle):
  - Map each nibble to its glyph.
  - Sign is minus if the captured sign bit is 1, otherwise blank. Zero is always shown unsigned.
  - Register Sign and Magnitude, set valid=1 for the next cycle, set busy=0, and return to IDLE.
- Latency:
  - load accepted at edge k.
  - Outputs change at edge k+WIDTH+1.
  - valid is high for the cycle after that edge.
  - The next load can be accepted at edge k+WIDTH+2.
- load while busy=1 is ignored: no queueing, and N is not re-captured.
- load=1 in the cycle where valid=1 is accepted, because the FSM is already in IDLE.
- reset and load in the same cycle: reset wins.
- reset during SHIFT or ENCODE aborts the conversion. Outputs go to their reset values and no valid pulse is produced.
- N may change freely while busy. Only the value captured at acceptance is converted.
- Sign and Magnitude are stable between valid pulses.

Optional Feature:
- Macro: TC7SEG_LZB_EN.
- Defined:
  - Leading-zero blanking. Any digit more significant than the highest non-zero digit shows blank.
  - The least significant digit is always shown; input 0 displays a single 0.
  - The sign display is unaffected.
- Undefined: all DIGITS digits always show their glyph, including leading zeros.
- Latency is identical in both builds.

Test Plan:
- Reset, no load -> Sign=1111111, all digits 1111111, busy=0, valid=0.
- WIDTH=8, DIGITS=3, load N=8'h80 -> busy high for 9 cycles. Then valid pulse with Sign=0111111 and digits (MS..LS) 1,2,8 = 1111001, 0100100, 0000000.
- N=8'h7F -> Sign=1111111, digits 1,2,7. N=8'h00 -> Sign blank, LS digit 1000000; upper digits blank with TC7SEG_LZB_EN, 1000000 without.
- N=8'hFF -> Sign=0111111, LS digit 1111001; upper two digits blank with TC7SEG_LZB_EN, 1000000 without.
- Load N=8'h05, then pulse load with N=8'h80 at cycle 3 while busy, then assert reset at cycle 6 -> the second load is ignored, outputs return to blank, and no valid pulse occurs. A fresh load after reset converts normally.
- WIDTH=4, DIGITS=1, sweep all 16 values -> each result matches its signed decimal value. -8 shows minus and 8; -1 shows minus and 1; +7 shows a blank sign and 7.

Source files
------------

// File: rtl/tc_to_7seg_multi.sv
// Sequential two's-complement to multi-digit 7-segment driver.
// Captures a signed operand on load, converts |N| to BCD with an iterative
// shift-add-3 engine, then registers active-low sign and digit glyphs.
// Optional feature macro: TC7SEG_LZB_EN (leading-zero blanking).
module tc_to_7seg_multi #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      N,
  output logic                  busy,
  output logic                  valid,
  output logic [6:0]            Sign,
  output logic [7*DIGITS-1:0]   Magnitude
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_MINUS = 7'b0111111;

  // True when DIGITS decimal digits can hold 2^(w-1).
  function automatic bit digits_fit(input int unsigned d, input int unsigned w);
    longint unsigned p;
    longint unsigned lim;
    p   = 64'd1;
    lim = 64'd1 << (w - 1);
    for (int unsigned i = 0; i < d; i++) begin
      if (p > lim) return 1'b1;
      p = p * 64'd10;
    end
    return p > lim;
  endfunction

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_chk
    $error("tc_to_7seg_multi: WIDTH must be in 2..16");
  end
  if (!digits_fit(DIGITS, WIDTH)) begin : g_digits_chk
    $error("tc_to_7seg_multi: DIGITS too small for WIDTH");
  end

  // Active-low glyph for one BCD digit; non-decimal codes show blank.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [BCD_W-1:0]      bcd_adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [6:0]            sign_seg_q, sign_seg_d;
  logic [7*DIGITS-1:0]   mag_seg_q, mag_seg_d;
`ifdef TC7SEG_LZB_EN
  logic                  lz_seen;
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      sign_seg_q <= SEG_BLANK;
      mag_seg_q  <= '1;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      sign_seg_q <= sign_seg_d;
      mag_seg_q  <= mag_seg_d;
    end
  end

  // Next-state logic: capture, double-dabble shifting, glyph encoding.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    sign_seg_d = sign_seg_q;
    mag_seg_d  = mag_seg_q;
    bcd_adj    = bcd_q;
`ifdef TC7SEG_LZB_EN
    lz_seen    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (load) begin
          sign_d  = N[WIDTH-1];
          // Negating the most negative value wraps to 2^(WIDTH-1) unsigned.
          mag_d   = N[WIDTH-1] ? (~N + WIDTH'(1)) : N;
          bcd_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
          end
        end
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ENCODE;
        end
      end

      ENCODE: begin
        // A set sign bit implies a non-zero magnitude, so zero stays unsigned.
        sign_seg_d = sign_q ? SEG_MINUS : SEG_BLANK;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
`ifdef TC7SEG_LZB_EN
          if ((bcd_q[4*i +: 4] != 4'd0) || (i == 0)) begin
            lz_seen = 1'b1;
          end
          mag_seg_d[7*i +: 7] = lz_seen ? glyph(bcd_q[4*i +: 4]) : SEG_BLANK;
`else
          mag_seg_d[7*i +: 7] = glyph(bcd_q[4*i +: 4]);
`endif
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign Sign      = sign_seg_q;
  assign Magnitude = mag_seg_q;

endmodule

// File: tb/tb_tc_to_7seg_multi.sv
// Self-checking bench for tc_to_7seg_multi: instance A (WIDTH=8, DIGITS=3)
// and instance B (WIDTH=4, DIGITS=1), each checked every cycle against a
// cycle-count behavioural model plus hand-computed literal expectations.
module tb_tc_to_7seg_multi;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G5 = 7'b0010010, G7 = 7'b1111000, G8 = 7'b0000000;
  localparam logic [6:0] BLK = 7'b1111111, MIN = 7'b0111111;

  logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, load_a = 1'b0;
  logic [7:0]  n_a = '0;
  logic        busy_a, valid_a;
  logic [6:0]  sign_a;
  logic [20:0] mag_a;

  logic        rst_b = 1'b1, load_b = 1'b0;
  logic [3:0]  n_b = '0;
  logic        busy_b, valid_b;
  logic [6:0]  sign_b;
  logic [6:0]  mag_b;

  tc_to_7seg_multi #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .reset(rst_a), .load(load_a), .N(n_a),
    .busy(busy_a), .valid(valid_a), .Sign(sign_a), .Magnitude(mag_a));

  tc_to_7seg_multi #(.WIDTH(4), .DIGITS(1)) u_b (
    .clk(clk), .reset(rst_b), .load(load_b), .N(n_b),
    .busy(busy_b), .valid(valid_b), .Sign(sign_b), .Magnitude(mag_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a conversion is a fixed-length delay after acceptance.
  typedef struct {
    int          rem;
    int          val;
    logic        busy;
    logic        valid;
    logic [6:0]  sign;
    logic [20:0] mag;
  } model_t;

  function automatic logic [20:0] disp_mag(input int v, input int digits);
    logic [20:0] r;
    int m;
    int p;
    logic blank;
    r = '1;
    m = (v < 0) ? -v : v;
    p = 1;
    for (int i = 0; i < digits; i++) begin
`ifdef TC7SEG_LZB_EN
      blank = (i > 0) && (m < p);
`else
      blank = 1'b0;
`endif
      r[7*i +: 7] = blank ? BLK : glyph_tab[(m / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic model_t step(input model_t m, input logic rst, input logic ld,
                                  input int v, input int width, input int digits);
    model_t r;
    r = m;
    if (rst) begin
      r.rem = 0; r.val = 0; r.busy = 1'b0; r.valid = 1'b0;
      r.sign = BLK; r.mag = '1;
      return r;
    end
    r.valid = 1'b0;
    if (r.rem > 0) begin
      r.rem--;
      if (r.rem == 0) begin
        r.busy  = 1'b0;
        r.valid = 1'b1;
        r.sign  = (r.val < 0) ? MIN : BLK;
        r.mag   = disp_mag(r.val, digits);
      end
    end else if (ld) begin
      r.val  = v;
      r.rem  = width + 1;
      r.busy = 1'b1;
    end
    return r;
  endfunction

  model_t ma, mb;
  bit chk_en = 1'b0;

  // Advance both models on every rising edge from the inputs the DUTs see.
  always @(posedge clk) begin
    int va, vb;
    va = $signed(n_a);
    vb = $signed(n_b);
    ma = step(ma, rst_a, load_a, va, 8, 3);
    mb = step(mb, rst_b, load_b, vb, 4, 1);
    chk_en = 1'b1;
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("A.busy",  32'(busy_a),  32'(ma.busy));
      chk("A.valid", 32'(valid_a), 32'(ma.valid));
      chk("A.Sign",  32'(sign_a),  32'(ma.sign));
      chk("A.Mag",   32'(mag_a),   32'(ma.mag));
      chk("B.busy",  32'(busy_b),  32'(mb.busy));
      chk("B.valid", 32'(valid_b), 32'(mb.valid));
      chk("B.Sign",  32'(sign_b),  32'(mb.sign));
      chk("B.Mag",   32'(mag_b),   32'(mb.mag[6:0]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for a valid pulse on one instance; counts busy cycles seen.
  task automatic wait_valid(input bit inst_b, input string name, output int busy_cycles);
    bit found;
    found = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (inst_b ? valid_b : valid_a) found = 1'b1;
      else if (inst_b ? busy_b : busy_a) busy_cycles++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: got no valid pulse expected one within 40 cycles", name);
    end
  endtask

  task automatic conv_a(input logic [7:0] v, input string name, output int bc);
    load_a = 1'b1; n_a = v;
    cyc();
    load_a = 1'b0; n_a = 8'($urandom);
    wait_valid(1'b0, name, bc);
  endtask

  initial begin
    int bc;
    int vcount;
    logic [20:0] e;

    cyc(); cyc();
    @(negedge clk);
    chk("rst.A.busy", 32'(busy_a), 32'(0));
    chk("rst.A.valid", 32'(valid_a), 32'(0));
    chk("rst.A.Sign", 32'(sign_a), 32'(BLK));
    chk("rst.A.Mag", 32'(mag_a), 32'({BLK, BLK, BLK}));
    chk("rst.B.Mag", 32'(mag_b), 32'(BLK));
    rst_a = 1'b0; rst_b = 1'b0;
    cyc();

    conv_a(8'h80, "A.80.valid", bc);
    chk("A.80.busy_cycles", 32'(bc), 32'd9);
    chk("A.80.Sign", 32'(sign_a), 32'(MIN));
    chk("A.80.Mag", 32'(mag_a), 32'({G1, G2, G8}));

    conv_a(8'h7F, "A.7F.valid", bc);
    chk("A.7F.Sign", 32'(sign_a), 32'(BLK));
    chk("A.7F.Mag", 32'(mag_a), 32'({G1, G2, G7}));

    conv_a(8'h00, "A.00.valid", bc);
`ifdef TC7SEG_LZB_EN
    e = {BLK, BLK, G0};
`else
    e = {G0, G0, G0};
`endif
    chk("A.00.Sign", 32'(sign_a), 32'(BLK));
    chk("A.00.Mag", 32'(mag_a), 32'(e));

    conv_a(8'hFF, "A.FF.valid", bc);
`ifdef TC7SEG_LZB_EN
    e = {BLK, BLK, G1};
`else
    e = {G0, G0, G1};
`endif
    chk("A.FF.Sign", 32'(sign_a), 32'(MIN));
    chk("A.FF.Mag", 32'(mag_a), 32'(e));

    // Abort: load 05, ignored load while busy, then reset mid-conversion.
    cyc();
    load_a = 1'b1; n_a = 8'h05; cyc();
    load_a = 1'b0; cyc(); cyc();
    load_a = 1'b1; n_a = 8'h80; cyc();
    load_a = 1'b0; cyc(); cyc();
    rst_a = 1'b1; cyc();
    rst_a = 1'b0;
    @(negedge clk);
    chk("abort.busy", 32'(busy_a), 32'(0));
    chk("abort.Sign", 32'(sign_a), 32'(BLK));
    chk("abort.Mag", 32'(mag_a), 32'({BLK, BLK, BLK}));
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid_a) vcount++;
    end
    chk("abort.no_valid", 32'(vcount), 32'd0);
    cyc();
    conv_a(8'h05, "A.05.valid", bc);
`ifdef TC7SEG_LZB_EN
    e = {BLK, BLK, G5};
`else
    e = {G0, G0, G5};
`endif
    chk("A.05.Sign", 32'(sign_a), 32'(BLK));
    chk("A.05.Mag", 32'(mag_a), 32'(e));

    // WIDTH=4 sweep of every code.
    for (int v = 0; v < 16; v++) begin
      cyc();
      load_b = 1'b1; n_b = 4'(v);
      cyc();
      load_b = 1'b0;
      wait_valid(1'b1, "B.sweep.valid", bc);
      if (v == 8) begin
        chk("B.-8.Sign", 32'(sign_b), 32'(MIN));
        chk("B.-8.Mag", 32'(mag_b), 32'(G8));
      end
      if (v == 15) begin
        chk("B.-1.Sign", 32'(sign_b), 32'(MIN));
        chk("B.-1.Mag", 32'(mag_b), 32'(G1));
      end
      if (v == 7) begin
        chk("B.+7.Sign", 32'(sign_b), 32'(BLK));
        chk("B.+7.Mag", 32'(mag_b), 32'(G7));
      end
    end

    // Random traffic on both instances, including loads while busy and resets.
    for (int i = 0; i < 2000; i++) begin
      cyc();
      load_a = ($urandom_range(2) == 0);
      n_a    = 8'($urandom);
      rst_a  = ($urandom_range(60) == 0);
      load_b = ($urandom_range(2) == 0);
      n_b    = 4'($urandom);
      rst_b  = ($urandom_range(60) == 0);
    end
    cyc();
    load_a = 1'b0; load_b = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    for (int i = 0; i < 15; i++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
